// File: rtl/wt_dcache_rdport_ctrl_pkg.sv
// Shared widths and the read-port state encoding for the write-through dcache.
package wt_dcache_rdport_ctrl_pkg;

    localparam int unsigned PLEN               = 56;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;
    localparam int unsigned DCACHE_SET_ASSOC   = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MISS_REQ,
        MISS_WAIT,
        KILL_MISS,
        KILL_MISS_ACK,
        REPLAY_REQ,
        REPLAY_READ
    } rd_state_e;

endpackage

// File: rtl/wt_dcache_rdport_ctrl.sv
// Read-port controller: hit lookup, miss handoff, kill handling and replay
// with priority escalation after repeated replays.
module wt_dcache_rdport_ctrl
    import wt_dcache_rdport_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Ways      = DCACHE_SET_ASSOC,
    parameter int unsigned ReplayThr = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cache_en_i,
    input  logic                          stall_i,
    input  logic                          req_i,
    output logic                          gnt_o,
    input  logic                          kill_i,
    input  logic                          tag_valid_i,
    input  logic [DCACHE_TAG_WIDTH-1:0]   tag_i,
    input  logic [DCACHE_INDEX_WIDTH-1:0] addr_i,
    input  logic [1:0]                    size_i,
    output logic                          rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    input  logic                          nc_region_i,
    output logic                          miss_req_o,
    input  logic                          miss_ack_i,
    input  logic                          miss_replay_i,
    input  logic                          miss_rtrn_vld_i,
    output logic [PLEN-1:0]               miss_paddr_o,
    output logic                          miss_nc_o,
    output logic [2:0]                    miss_size_o,
    output logic [Ways-1:0]               miss_vld_bits_o,
    output logic                          rd_req_o,
    output logic                          rd_prio_o,
    input  logic                          rd_ack_i,
    output logic [DCACHE_TAG_WIDTH-1:0]   rd_tag_o,
    output logic [DCACHE_INDEX_WIDTH-1:0] rd_addr_o,
    input  logic [DataWidth-1:0]          rd_data_i,
    input  logic [Ways-1:0]               rd_vld_bits_i,
    input  logic [Ways-1:0]               rd_hit_oh_i,
    input  logic                          wr_cl_vld_i
);

    // state         | meaning
    // IDLE          | waiting for a core request to be granted
    // READ          | granted, waiting for the tag to resolve hit/miss
    // MISS_REQ      | miss request presented, waiting for ack or replay
    // MISS_WAIT     | miss accepted, waiting for the return data
    // KILL_MISS     | killed after ack, draining the miss return
    // KILL_MISS_ACK | killed before ack, still owes the miss handshake
    // REPLAY_REQ    | re-arbitrating for the cache read
    // REPLAY_READ   | replayed read issued, resolving with the saved tag

    localparam int unsigned             CntWidth = $clog2(ReplayThr + 1);
    localparam logic [CntWidth-1:0]     CntMax   = CntWidth'(ReplayThr);

    rd_state_e                     state_d, state_q;
    logic [DCACHE_TAG_WIDTH-1:0]   tag_d, tag_q;
    logic [DCACHE_INDEX_WIDTH-1:0] addr_d, addr_q;
    logic [1:0]                    size_d, size_q;
    logic [Ways-1:0]               vld_d, vld_q;
    logic [CntWidth-1:0]           cnt_d, cnt_q;
    logic                          rd_req_d, rd_req_q;
    logic                          rd_ack_d, rd_ack_q;
    logic                          save_tag;
    logic                          hit;

    assign hit = (|rd_hit_oh_i) & cache_en_i;

    always_comb begin
        state_d    = state_q;
        rd_req_o   = 1'b0;
        miss_req_o = 1'b0;
        gnt_o      = 1'b0;
        rvalid_o   = 1'b0;
        save_tag   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i && !stall_i) begin
                    rd_req_o = 1'b1;
                    if (rd_ack_i) begin
                        gnt_o   = 1'b1;
                        state_d = READ;
                    end
                end
            end
            READ, REPLAY_READ: begin
                rd_req_o = 1'b1;
                if (kill_i) begin
                    rvalid_o = 1'b1;
                    state_d  = IDLE;
                end else if (tag_valid_i || (state_q == REPLAY_READ)) begin
                    save_tag = (state_q == READ);
                    // a lost arbitration or a concurrent line write leaves the readout stale
                    if (wr_cl_vld_i || !rd_ack_q) begin
                        state_d = REPLAY_REQ;
                    end else if (hit) begin
                        rvalid_o = 1'b1;
                        state_d  = IDLE;
                        if (req_i && rd_ack_i && !stall_i) begin
                            gnt_o   = 1'b1;
                            state_d = READ;
                        end
                    end else begin
                        state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                miss_req_o = 1'b1;
                if (kill_i) begin
                    rvalid_o = 1'b1;
                    state_d  = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
                end else if (miss_replay_i) begin
                    state_d = REPLAY_REQ;
                end else if (miss_ack_i) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (miss_rtrn_vld_i) begin
                    rvalid_o = 1'b1;
                    state_d  = IDLE;
                end else if (kill_i) begin
                    rvalid_o = 1'b1;
                    state_d  = KILL_MISS;
                end
            end
            REPLAY_REQ: begin
                rd_req_o = 1'b1;
                if (kill_i) begin
                    rvalid_o = 1'b1;
                    state_d  = IDLE;
                end else if (rd_ack_i) begin
                    state_d = REPLAY_READ;
                end
            end
            KILL_MISS_ACK: begin
                miss_req_o = 1'b1;
                if (miss_replay_i) begin
                    state_d = IDLE;
                end else if (miss_ack_i) begin
                    state_d = KILL_MISS;
                end
            end
            KILL_MISS: begin
                if (miss_rtrn_vld_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // handshake outputs stay quiet while reset is held, whatever the inputs do
        if (!rst_ni) begin
            rd_req_o   = 1'b0;
            miss_req_o = 1'b0;
            gnt_o      = 1'b0;
            rvalid_o   = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (gnt_o || ((state_d == IDLE) && (state_q != IDLE))) begin
            cnt_d = '0;
        end else if ((state_d == REPLAY_REQ) && (state_q != REPLAY_REQ) && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    assign addr_d   = gnt_o    ? addr_i        : addr_q;
    assign size_d   = gnt_o    ? size_i        : size_q;
    assign tag_d    = save_tag ? tag_i         : tag_q;
    assign vld_d    = rd_req_q ? rd_vld_bits_i : vld_q;
    assign rd_req_d = rd_req_o;
    assign rd_ack_d = rd_ack_i;

    assign rdata_o         = rd_data_i;
    assign rd_addr_o       = addr_d;
    assign rd_tag_o        = tag_d;
    assign miss_paddr_o    = {tag_q, addr_q};
    assign miss_nc_o       = rst_ni & (~cache_en_i | nc_region_i);
    assign miss_size_o     = miss_nc_o ? {1'b0, size_q} : 3'b111;
    assign miss_vld_bits_o = vld_q;
    assign rd_prio_o       = rd_req_o & (cnt_q == CntMax);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            vld_q    <= '0;
            cnt_q    <= '0;
            rd_req_q <= 1'b0;
            rd_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            rd_req_q <= rd_req_d;
            rd_ack_q <= rd_ack_d;
        end
    end

`ifndef SYNTHESIS
    size_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (gnt_o && (DataWidth == 32)) |-> (size_i != 2'd3))
        else $error("64-bit access requested on a 32-bit read port");

    hit_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rd_ack_q && cache_en_i) |-> $onehot0(rd_hit_oh_i))
        else $error("rd_hit_oh_i is not one-hot0");
`endif

endmodule

// File: tb/tb_wt_dcache_rdport_ctrl.sv
// Randomized and directed checks of the read-port controller against a
// transaction-level model of its request/miss/replay protocol.
module tb_wt_dcache_rdport_ctrl;

    localparam int TW   = wt_dcache_rdport_ctrl_pkg::DCACHE_TAG_WIDTH;
    localparam int IW   = wt_dcache_rdport_ctrl_pkg::DCACHE_INDEX_WIDTH;
    localparam int PL   = wt_dcache_rdport_ctrl_pkg::PLEN;
    localparam int WAYS = wt_dcache_rdport_ctrl_pkg::DCACHE_SET_ASSOC;
    localparam int DW   = 64;
    localparam int THR  = 2;

    localparam int PH_IDLE = 0, PH_READ = 1, PH_MREQ = 2, PH_MWAIT = 3;
    localparam int PH_KMISS = 4, PH_KACK = 5, PH_RREQ = 6, PH_RREAD = 7;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic cache_en_i, stall_i, req_i, gnt_o, kill_i, tag_valid_i;
    logic [TW-1:0] tag_i;
    logic [IW-1:0] addr_i;
    logic [1:0]    size_i;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          nc_region_i, miss_req_o, miss_ack_i, miss_replay_i, miss_rtrn_vld_i;
    logic [PL-1:0] miss_paddr_o;
    logic          miss_nc_o;
    logic [2:0]    miss_size_o;
    logic [WAYS-1:0] miss_vld_bits_o;
    logic          rd_req_o, rd_prio_o, rd_ack_i;
    logic [TW-1:0] rd_tag_o;
    logic [IW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_i;
    logic [WAYS-1:0] rd_vld_bits_i, rd_hit_oh_i;
    logic          wr_cl_vld_i;

    always #5 clk_i = ~clk_i;

    wt_dcache_rdport_ctrl #(.DataWidth(DW), .Ways(WAYS), .ReplayThr(THR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cache_en_i(cache_en_i), .stall_i(stall_i),
        .req_i(req_i), .gnt_o(gnt_o), .kill_i(kill_i), .tag_valid_i(tag_valid_i),
        .tag_i(tag_i), .addr_i(addr_i), .size_i(size_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .nc_region_i(nc_region_i), .miss_req_o(miss_req_o),
        .miss_ack_i(miss_ack_i), .miss_replay_i(miss_replay_i),
        .miss_rtrn_vld_i(miss_rtrn_vld_i), .miss_paddr_o(miss_paddr_o),
        .miss_nc_o(miss_nc_o), .miss_size_o(miss_size_o),
        .miss_vld_bits_o(miss_vld_bits_o), .rd_req_o(rd_req_o), .rd_prio_o(rd_prio_o),
        .rd_ack_i(rd_ack_i), .rd_tag_o(rd_tag_o), .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i), .rd_vld_bits_i(rd_vld_bits_i), .rd_hit_oh_i(rd_hit_oh_i),
        .wr_cl_vld_i(wr_cl_vld_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model of the transaction in flight
    int            m_ph = PH_IDLE;
    int            m_cnt = 0;
    logic [TW-1:0] m_tag = '0;
    logic [IW-1:0] m_addr = '0;
    logic [1:0]    m_size = '0;
    logic [WAYS-1:0] m_vld = '0;
    logic          m_req_prev = 1'b0, m_ack_prev = 1'b0;

    // samples of the last stepped cycle, for literal checks
    logic          s_gnt, s_rvalid, s_rd_req, s_miss_req, s_prio, s_nc;
    logic [2:0]    s_size;
    logic [IW-1:0] s_rd_addr;
    logic [TW-1:0] s_rd_tag;
    logic [PL-1:0] s_paddr;
    logic [DW-1:0] s_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic quiet();
        req_i = 1'b0; stall_i = 1'b0; kill_i = 1'b0; tag_valid_i = 1'b0;
        wr_cl_vld_i = 1'b0; rd_hit_oh_i = '0; cache_en_i = 1'b1; nc_region_i = 1'b0;
        miss_ack_i = 1'b0; miss_replay_i = 1'b0; miss_rtrn_vld_i = 1'b0; rd_ack_i = 1'b1;
        rd_data_i = {$urandom, $urandom};
        rd_vld_bits_i = WAYS'($urandom);
    endtask

    // Evaluate one cycle: called #1 after a rising edge with inputs applied,
    // returns #1 after the next rising edge.
    task automatic step();
        logic e_rdreq, e_mreq, e_gnt, e_rv, e_save, e_nc, hit;
        logic [TW-1:0] e_tag;
        logic [IW-1:0] e_addr;
        int nx;
        #2;
        e_rdreq = 0; e_mreq = 0; e_gnt = 0; e_rv = 0; e_save = 0;
        nx  = m_ph;
        hit = (rd_hit_oh_i != '0) && cache_en_i;
        if (!rst_ni) begin
            m_ph = PH_IDLE; m_cnt = 0; m_tag = '0; m_addr = '0; m_size = '0;
            m_vld = '0; m_req_prev = 0; m_ack_prev = 0; nx = PH_IDLE;
            e_nc = 1'b0;
        end else begin
            e_nc = !cache_en_i || nc_region_i;
            if (m_ph == PH_IDLE) begin
                if (req_i && !stall_i) begin
                    e_rdreq = 1;
                    if (rd_ack_i) begin e_gnt = 1; nx = PH_READ; end
                end
            end else if (m_ph == PH_READ || m_ph == PH_RREAD) begin
                e_rdreq = 1;
                if (kill_i) begin
                    e_rv = 1; nx = PH_IDLE;
                end else if (tag_valid_i || m_ph == PH_RREAD) begin
                    e_save = (m_ph == PH_READ);
                    if (wr_cl_vld_i || !m_ack_prev) nx = PH_RREQ;
                    else if (hit) begin
                        e_rv = 1; nx = PH_IDLE;
                        if (req_i && rd_ack_i && !stall_i) begin e_gnt = 1; nx = PH_READ; end
                    end else nx = PH_MREQ;
                end
            end else if (m_ph == PH_MREQ) begin
                e_mreq = 1;
                if (kill_i) begin e_rv = 1; nx = miss_ack_i ? PH_KMISS : PH_KACK; end
                else if (miss_replay_i) nx = PH_RREQ;
                else if (miss_ack_i) nx = PH_MWAIT;
            end else if (m_ph == PH_MWAIT) begin
                if (miss_rtrn_vld_i) begin e_rv = 1; nx = PH_IDLE; end
                else if (kill_i) begin e_rv = 1; nx = PH_KMISS; end
            end else if (m_ph == PH_RREQ) begin
                e_rdreq = 1;
                if (kill_i) begin e_rv = 1; nx = PH_IDLE; end
                else if (rd_ack_i) nx = PH_RREAD;
            end else if (m_ph == PH_KACK) begin
                e_mreq = 1;
                if (miss_replay_i) nx = PH_IDLE;
                else if (miss_ack_i) nx = PH_KMISS;
            end else begin
                if (miss_rtrn_vld_i) nx = PH_IDLE;
            end
        end
        e_tag  = e_save ? tag_i : m_tag;
        e_addr = e_gnt ? addr_i : m_addr;

        chk("gnt",       64'(gnt_o),           64'(e_gnt));
        chk("rvalid",    64'(rvalid_o),        64'(e_rv));
        chk("rd_req",    64'(rd_req_o),        64'(e_rdreq));
        chk("miss_req",  64'(miss_req_o),      64'(e_mreq));
        chk("rd_prio",   64'(rd_prio_o),       64'(e_rdreq && (m_cnt == THR)));
        chk("rd_addr",   64'(rd_addr_o),       64'(e_addr));
        chk("rd_tag",    64'(rd_tag_o),        64'(e_tag));
        chk("paddr",     64'(miss_paddr_o),    64'({m_tag, m_addr}));
        chk("miss_nc",   64'(miss_nc_o),       64'(e_nc));
        chk("miss_size", 64'(miss_size_o),     e_nc ? 64'(m_size) : 64'd7);
        chk("vld_bits",  64'(miss_vld_bits_o), 64'(m_vld));
        chk("rdata",     64'(rdata_o),         64'(rd_data_i));

        s_gnt = gnt_o; s_rvalid = rvalid_o; s_rd_req = rd_req_o; s_miss_req = miss_req_o;
        s_prio = rd_prio_o; s_nc = miss_nc_o; s_size = miss_size_o; s_rd_addr = rd_addr_o;
        s_rd_tag = rd_tag_o; s_paddr = miss_paddr_o; s_rdata = rdata_o;

        if (rst_ni) begin
            if (e_gnt || nx == PH_IDLE) m_cnt = 0;
            else if (nx == PH_RREQ && m_ph != PH_RREQ) m_cnt = (m_cnt < THR) ? m_cnt + 1 : THR;
            m_tag  = e_tag;
            m_addr = e_addr;
            if (e_gnt) m_size = size_i;
            if (m_req_prev) m_vld = rd_vld_bits_i;
            m_req_prev = e_rdreq;
            m_ack_prev = rd_ack_i;
            m_ph = nx;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic grant(input logic [IW-1:0] a, input logic [1:0] sz);
        quiet(); req_i = 1; addr_i = a; size_i = sz;
        step();
    endtask

    initial begin
        tag_i = '0; addr_i = '0; size_i = '0;
        quiet();
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        // reset with an active request on the inputs
        req_i = 1; nc_region_i = 1;
        step();
        chk("reset_gnt",   64'(s_gnt),    64'd0);
        chk("reset_nc",    64'(s_nc),     64'd0);
        chk("reset_size",  64'(s_size),   64'd7);
        step();
        rst_ni = 1'b1;

        // single hit
        grant(12'h040, 2'd3);
        chk("hit_gnt_c0",  64'(s_gnt),     64'd1);
        chk("hit_addr_c0", 64'(s_rd_addr), 64'h040);
        quiet(); tag_valid_i = 1; tag_i = TW'(44'h12); rd_hit_oh_i = WAYS'(4'b0010);
        rd_data_i = 64'hDEADBEEF_0BADF00D;
        step();
        chk("hit_rvalid_c1", 64'(s_rvalid), 64'd1);
        chk("hit_rdata_c1",  64'(s_rdata),  64'hDEADBEEF_0BADF00D);
        chk("hit_tag_c1",    64'(s_rd_tag), 64'h12);

        // noncacheable miss, return three cycles after ack
        grant(12'h100, 2'd2);
        quiet(); tag_valid_i = 1; tag_i = TW'(44'h33);
        step();
        quiet(); nc_region_i = 1; miss_ack_i = 1;
        step();
        chk("nc_miss_req",  64'(s_miss_req), 64'd1);
        chk("nc_miss_nc",   64'(s_nc),       64'd1);
        chk("nc_miss_size", 64'(s_size),     64'd2);
        chk("nc_paddr",     64'(s_paddr),    64'h33_100);
        quiet(); step(); step();
        chk("nc_wait_rv",   64'(s_rvalid),   64'd0);
        quiet(); miss_rtrn_vld_i = 1;
        step();
        chk("nc_rtrn_rv",   64'(s_rvalid),   64'd1);
        grant(12'h008, 2'd0);
        chk("nc_idle_gnt",  64'(s_gnt),      64'd1);
        quiet(); kill_i = 1; step();

        // kill before miss ack, released by replay
        grant(12'h200, 2'd1);
        quiet(); tag_valid_i = 1; tag_i = TW'(44'h44); step();
        quiet(); kill_i = 1; step();
        chk("kill_rv",      64'(s_rvalid),   64'd1);
        quiet(); miss_replay_i = 1; step();
        chk("kack_mreq",    64'(s_miss_req), 64'd1);
        grant(12'h204, 2'd1);
        chk("kill_idle_gnt", 64'(s_gnt),     64'd1);
        quiet(); kill_i = 1; step();

        // replay escalation
        grant(12'h300, 2'd3);
        quiet(); tag_valid_i = 1; tag_i = TW'(44'h55); wr_cl_vld_i = 1; step();
        quiet(); step();
        chk("replay1_prio", 64'(s_prio), 64'd0);
        quiet(); wr_cl_vld_i = 1; step();
        quiet(); step();
        chk("replay2_prio", 64'(s_prio), 64'd1);
        quiet(); wr_cl_vld_i = 1; step();
        quiet(); step();
        chk("replay3_prio", 64'(s_prio), 64'd1);
        quiet(); rd_hit_oh_i = WAYS'(1); req_i = 1; addr_i = 12'h310; step();
        chk("replay_hit_gnt", 64'(s_gnt), 64'd1);
        quiet(); step();
        chk("prio_cleared", 64'(s_prio), 64'd0);
        chk("prio_rdreq",   64'(s_rd_req), 64'd1);
        quiet(); kill_i = 1; step();

        // back-to-back hits
        grant(12'h400, 2'd3);
        quiet(); tag_valid_i = 1; tag_i = TW'(44'h66); rd_hit_oh_i = WAYS'(4'b0100);
        req_i = 1; addr_i = 12'h408; step();
        chk("b2b_rv1",  64'(s_rvalid), 64'd1);
        chk("b2b_gnt2", 64'(s_gnt),    64'd1);
        quiet(); tag_valid_i = 1; tag_i = TW'(44'h66); rd_hit_oh_i = WAYS'(4'b0100); step();
        chk("b2b_rv2",  64'(s_rvalid), 64'd1);
        chk("b2b_addr", 64'(s_paddr),  64'h66_408);

        // reset in the middle of a miss
        grant(12'h500, 2'd2);
        quiet(); tag_valid_i = 1; tag_i = TW'(44'h77); step();
        quiet(); miss_ack_i = 1; step();
        quiet(); rst_ni = 1'b0; step();
        chk("midrst_paddr", 64'(s_paddr), 64'd0);
        rst_ni = 1'b1;
        grant(12'h504, 2'd2);
        chk("midrst_gnt",   64'(s_gnt),   64'd1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            req_i           = ($urandom_range(99, 0) < 60);
            stall_i         = ($urandom_range(99, 0) < 10);
            rd_ack_i        = ($urandom_range(99, 0) < 80);
            kill_i          = ($urandom_range(99, 0) < 4);
            tag_valid_i     = ($urandom_range(99, 0) < 60);
            wr_cl_vld_i     = ($urandom_range(99, 0) < 8);
            cache_en_i      = ($urandom_range(99, 0) < 90);
            nc_region_i     = ($urandom_range(99, 0) < 20);
            miss_ack_i      = ($urandom_range(99, 0) < 40);
            miss_replay_i   = ($urandom_range(99, 0) < 10);
            miss_rtrn_vld_i = ($urandom_range(99, 0) < 30);
            rst_ni          = ($urandom_range(999, 0) >= 3);
            rd_hit_oh_i     = ($urandom_range(1, 0) == 0) ? '0
                              : (WAYS'(1) << $urandom_range(WAYS - 1, 0));
            tag_i           = TW'({$urandom, $urandom});
            addr_i          = IW'($urandom);
            size_i          = 2'($urandom);
            rd_data_i       = {$urandom, $urandom};
            rd_vld_bits_i   = WAYS'($urandom);
            step();
        end
        rst_ni = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
